// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: default widths, register-0 constant, EX/MEM payload layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Architectural register that never receives a write-back.
  localparam int ZERO_REG = 0;

  // EX/MEM payload at the default widths; wb sits in the MSB.
  typedef struct packed {
    logic                  wb;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_ADDR_W-1:0] dst_addr;
  } ex_mem_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready register stage with a one-entry skid buffer and synchronous flush.
// Latency: 1 cycle from accept to out_valid when the stage is empty; 1 transfer per cycle sustained.
// Backpressure: in_ready is a flop (~skid_valid); out_ready has no combinational path to in_ready.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic [W-1:0] main_dat;
  logic         skid_vld;
  logic [W-1:0] skid_dat;
  logic         accept;
  logic         pop;

  assign accept    = in_valid & in_ready;
  assign pop       = main_vld & out_ready;
  // Skid empty means one more entry fits even if MEM stalls this cycle.
  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

  // Main/skid update: reset over flush over handshake; main always holds the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (flush) begin
      // Data fields keep stale values; only the valid bits matter.
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || pop) begin
      if (skid_vld) begin
        main_vld <= 1'b1;
        main_dat <= skid_dat;
        skid_vld <= accept;
        if (accept) begin
          skid_dat <= in_data;
        end
      end else begin
        main_vld <= accept;
        if (accept) begin
          main_dat <= in_data;
        end
      end
    end else if (accept) begin
      // Main is stalled; park the new entry in the skid slot.
      skid_vld <= 1'b1;
      skid_dat <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_elastic.sv
// EX/MEM boundary: packs wb/result/dest, suppresses write-back to register 0, gates wb_out with valid.
// Latency: 1 cycle into an empty stage; one instruction per cycle with out_ready held high.
// Backpressure: registered in_ready from a 1-entry skid; stalls on either side lose nothing.
module ex_mem_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int ZERO_REG_NOWB = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [ADDR_W-1:0] dst_addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [ADDR_W-1:0] dst_addr_out
);

  // Same layout as ex_mem_t, sized by this instance's parameters.
  typedef struct packed {
    logic              wb;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] dst_addr;
  } entry_t;

  localparam int                ENTRY_W   = $bits(entry_t);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  entry_t in_entry;
  entry_t head;

  // Build the stored payload; register-0 writes are neutralised here so MEM never sees them.
  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = ALU_result_in;
    in_entry.dst_addr   = dst_addr_in;
    if (ZERO_REG_NOWB != 0) begin
      in_entry.wb = wb_in & (dst_addr_in != ZERO_ADDR);
    end else begin
      in_entry.wb = wb_in;
    end
  end

  pipe_skid_reg #(
    .W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  // Stale data after a flush must never trigger a write, so wb is qualified by valid.
  assign wb_out         = head.wb & out_valid;
  assign ALU_result_out = head.alu_result;
  assign dst_addr_out   = head.dst_addr;

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Directed bench for ex_mem_elastic: reset, streaming, skid backpressure, flush, register 0, mid-stall reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: driven explicitly through out_ready per scenario.
module tb_ex_mem_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        wb_in;
  logic [31:0] alu_in;
  logic [4:0]  dst_in;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_wb_out;
  logic [31:0] a_alu_out;
  logic [4:0]  a_dst_out;
  logic        b_in_ready, b_out_valid, b_wb_out;
  logic [31:0] b_alu_out;
  logic [4:0]  b_dst_out;

  int checks = 0;
  int errors = 0;

  // {out_valid, wb_out, ALU_result_out, dst_addr_out, in_ready}
  logic [39:0] a_obs, b_obs, exp_v;
  // {out_valid, wb_out, in_ready} for cases where data fields may be stale
  logic [2:0]  a_ctl, exp_c;

  assign a_obs = {a_out_valid, a_wb_out, a_alu_out, a_dst_out, a_in_ready};
  assign b_obs = {b_out_valid, b_wb_out, b_alu_out, b_dst_out, b_in_ready};
  assign a_ctl = {a_out_valid, a_wb_out, a_in_ready};

  always #5 clk = ~clk;

  ex_mem_elastic #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_NOWB(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .wb_in(wb_in), .ALU_result_in(alu_in), .dst_addr_in(dst_in),
    .out_valid(a_out_valid), .out_ready(out_ready), .wb_out(a_wb_out),
    .ALU_result_out(a_alu_out), .dst_addr_out(a_dst_out)
  );

  ex_mem_elastic #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_NOWB(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .wb_in(wb_in), .ALU_result_in(alu_in), .dst_addr_in(dst_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .wb_out(b_wb_out),
    .ALU_result_out(b_alu_out), .dst_addr_out(b_dst_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wb, input logic [31:0] alu, input logic [4:0] dst);
    in_valid = 1'b1;
    wb_in    = wb;
    alu_in   = alu;
    dst_in   = dst;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_in = 1'b0;
    alu_in = '0; dst_in = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_v = {1'b0, 1'b0, 32'h0, 5'd0, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL reset_state: got %h expected %h", a_obs, exp_v);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    push(1'b1, 32'h0000_00A5, 5'd3);
    tick();
    exp_v = {1'b1, 1'b1, 32'h0000_00A5, 5'd3, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL stream_first: got %h expected %h", a_obs, exp_v);
    end
    push(1'b1, 32'h1234_5678, 5'd7);
    tick();
    exp_v = {1'b1, 1'b1, 32'h1234_5678, 5'd7, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL stream_second: got %h expected %h", a_obs, exp_v);
    end
    in_valid = 1'b0;
    tick();
    exp_c = 3'b001;
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL stream_drain: got %b expected %b", a_ctl, exp_c);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(1'b1, 32'h11, 5'd1);
    tick();
    exp_v = {1'b1, 1'b1, 32'h11, 5'd1, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL bp_main_fill: got %h expected %h", a_obs, exp_v);
    end
    push(1'b1, 32'h22, 5'd2);
    tick();
    exp_v = {1'b1, 1'b1, 32'h11, 5'd1, 1'b0};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL bp_skid_fill: got %h expected %h", a_obs, exp_v);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL bp_hold_stable: got %h expected %h", a_obs, exp_v);
    end
    out_ready = 1'b1;
    tick();
    exp_v = {1'b1, 1'b1, 32'h22, 5'd2, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL bp_release_second: got %h expected %h", a_obs, exp_v);
    end
    tick();
    exp_c = 3'b001;
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL bp_drained: got %b expected %b", a_ctl, exp_c);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(1'b1, 32'h44, 5'd5);
    tick();
    push(1'b1, 32'h55, 5'd6);
    tick();
    exp_c = 3'b110;
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL flush_full_before: got %b expected %b", a_ctl, exp_c);
    end
    flush = 1'b1;
    push(1'b1, 32'h33, 5'd4);
    tick();
    exp_c = 3'b001;
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL flush_full_after: got %b expected %b", a_ctl, exp_c);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL flush_no_ghost: got %b expected %b", a_ctl, exp_c);
    end
    // Input accepted in the flush cycle into an empty stage must vanish.
    flush = 1'b1;
    push(1'b1, 32'hAB, 5'd10);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL flush_discard_accept: got %b expected %b", a_ctl, exp_c);
    end
    tick();
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL flush_discard_later: got %b expected %b", a_ctl, exp_c);
    end
  endtask

  task automatic test_zero_reg();
    out_ready = 1'b0;
    push(1'b1, 32'hDEAD_BEEF, 5'd0);
    tick();
    exp_v = {1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL zero_reg_nowb: got %h expected %h", a_obs, exp_v);
    end
    exp_v = {1'b1, 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1};
    checks++;
    if (b_obs !== exp_v) begin
      errors++; $display("FAIL zero_reg_wb_kept: got %h expected %h", b_obs, exp_v);
    end
    push(1'b0, 32'h77, 5'd8);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    exp_v = {1'b1, 1'b0, 32'h77, 5'd8, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL wb_zero_passthru: got %h expected %h", a_obs, exp_v);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    push(1'b1, 32'h66, 5'd1);
    tick();
    push(1'b1, 32'h67, 5'd2);
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = {1'b0, 1'b0, 32'h0, 5'd0, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL reset_mid_stall: got %h expected %h", a_obs, exp_v);
    end
    out_ready = 1'b1;
    push(1'b1, 32'h88, 5'd9);
    tick();
    exp_v = {1'b1, 1'b1, 32'h88, 5'd9, 1'b1};
    checks++;
    if (a_obs !== exp_v) begin
      errors++; $display("FAIL reset_then_push: got %h expected %h", a_obs, exp_v);
    end
    in_valid = 1'b0;
    tick();
    exp_c = 3'b001;
    checks++;
    if (a_ctl !== exp_c) begin
      errors++; $display("FAIL reset_then_drain: got %b expected %b", a_ctl, exp_c);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_zero_reg();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_elastic.md
Name: ex_mem_elastic

Overview:
- Parametrised EX/MEM pipeline boundary register with a valid/ready elastic handshake, a 1-entry skid buffer, synchronous flush and optional write-back suppression for register 0.
- Sits between the ALU (EX) and the memory/write-back side (MEM).
- Lets either side stall without losing or duplicating an instruction.
- Sustains one transfer per cycle with a fully registered in_ready.

Parameters:
- DATA_W, 32, width of ALU result
- ADDR_W, 5, width of destination register address
- ZERO_REG_NOWB, 1, when 1 an instruction with dst_addr_in == 0 is stored with wb = 0

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  EX presents a valid instruction
- in_ready  output  1  stage can accept; registered
- wb_in  input  1  write-back enable from EX
- ALU_result_in  input  DATA_W  ALU result from EX
- dst_addr_in  input  ADDR_W  destination register from EX
- out_valid  output  1  MEM side holds a valid instruction
- out_ready  input  1  MEM side consumes this cycle
- wb_out  output  1  write-back enable, gated: wb_main & out_valid
- ALU_result_out  output  DATA_W  result of head entry
- dst_addr_out  output  ADDR_W  destination of head entry

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Storage: main entry (drives outputs) and skid entry. Each entry holds wb, ALU_result, dst_addr and a valid bit.
- Reset values: out_valid=0, wb_out=0, ALU_result_out=0, dst_addr_out=0, skid_valid=0, in_ready=1 in the cycle after rst is sampled high.
- Accept: accept = in_valid & in_ready. Consume: pop = out_valid & out_ready.
- in_ready is registered and equals ~skid_valid. There is no combinational path from out_ready to in_ready.
- Latency: an entry accepted into an empty stage appears on the outputs next cycle.
- Throughput: with out_ready held at 1, one entry per cycle.
- Next-state rules (rst=0, flush=0):
  - main empty or pop, skid valid: main <- skid; skid <- input if accept, else skid empties.
  - main empty or pop, skid empty: main <- input if accept, else main empties.
  - main valid and no pop: main holds; skid <- input if accept.
- Ordering: entries leave in acceptance order. No drops, no duplicates.
- Flush: both valid bits are cleared next cycle. An input accepted in the same cycle is discarded. A pop in the same cycle still counts as consumed by MEM. Data fields may keep stale values, but wb_out=0 because out_valid=0. in_ready=1 the cycle after the flush.
- Priority: rst > flush > handshake.
- ZERO_REG_NOWB=1: the stored wb equals wb_in & (dst_addr_in != 0). ALU_result and dst_addr are stored unchanged.
- Outputs are stable while out_valid=1 and out_ready=0.
- Holding in_valid=1 while in_ready=0 is legal. No transfer occurs and EX must hold its data.
- Reset mid-operation: every held entry is lost and outputs return to reset values the next cycle.

Decomposition:
- Shared package pipe_pkg:
  - default widths (DATA_W=32, ADDR_W=5)
  - constant ZERO_REG = 0
  - packed struct ex_mem_t {wb, alu_result, dst_addr}
- One natural sub-module: pipe_skid_reg. It is a generic valid/ready skid register over a payload of width W, with flush, and is reusable for the ID_EX and MEM_WB successors.
- ex_mem_elastic does the wb gating, packs the payload and instantiates pipe_skid_reg.

Test Plan:
- Reset then idle: assert rst 2 cycles -> out_valid=0, wb_out=0, ALU_result_out=0, dst_addr_out=0, in_ready=1.
- Streaming: out_ready=1, push {wb=1, 0x0000_00A5, r3} then {1, 0x1234_5678, r7} on consecutive cycles -> outputs appear one cycle later each, in order, one per cycle.
- Backpressure/skid: out_ready=0, push {1, 0x11, r1} then {1, 0x22, r2} -> in_ready drops to 0 after the second accept. Raise out_ready -> 0x11 then 0x22 emerge; in_ready returns to 1; nothing lost.
- Flush with full skid: fill main and skid, then flush=1 with in_valid=1 {1, 0x33, r4} -> next cycle out_valid=0, wb_out=0, in_ready=1; 0x33 never appears.
- Zero register: ZERO_REG_NOWB=1, push {wb=1, 0xDEAD_BEEF, r0} -> out_valid=1, wb_out=0, ALU_result_out=0xDEAD_BEEF. With ZERO_REG_NOWB=0 the same push gives wb_out=1.
- Reset mid-stall: main and skid full, out_ready=0, rst=1 for 1 cycle -> all outputs at reset values, in_ready=1 next cycle; later pushes pass normally.
